// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: registered N:1 operand selector with skid entry, flush and
// out-of-range select detection; in_ready is a flop that mirrors skid emptiness.
module operand_sel_pipe #(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int SEL_W = NUM_IN > 1 ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err,
  output logic                    err_sticky
);
  logic [WIDTH-1:0] cap_data, skid_data;
  logic cap_err, skid_err, skid_valid, accept, drain;
  always_comb begin
    cap_data = RESET_VAL;
    cap_err = 1'b1;
    for (int i = 0; i < NUM_IN; i++)
      if (sel == SEL_W'(i)) begin
        cap_data = in_data[i*WIDTH +: WIDTH];
        cap_err = 1'b0;
      end
  end
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  // flush drops both entries but leaves out_data/out_err holding their last beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= RESET_VAL;
      out_err <= 1'b0;
      out_valid <= 1'b0;
      skid_data <= RESET_VAL;
      skid_err <= 1'b0;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky | (accept & cap_err);
      if (flush) begin
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
        in_ready <= 1'b1;
      end else if (skid_valid) begin
        if (drain) begin
          out_data <= skid_data;
          out_err <= skid_err;
          skid_valid <= 1'b0;
          in_ready <= 1'b1;
        end
      end else if (accept & (drain | !out_valid)) begin
        out_data <= cap_data;
        out_err <= cap_err;
        out_valid <= 1'b1;
      end else if (accept) begin
        skid_data <= cap_data;
        skid_err <= cap_err;
        skid_valid <= 1'b1;
        in_ready <= 1'b0;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
endmodule
